// File: rtl/west_feeder.sv
`default_nettype none
// ============================================================================
// Module   : west_feeder
// Brief    : Input FIFO plus command FSM that streams kernel-load / execute
//            words into the west edge of tile 0 of a systolic row.
//            Optional macro WEST_FEEDER_OCC_EN adds the FIFO occupancy port occ.
// Revision : 1.0 - initial release
// ============================================================================
module west_feeder #(
  parameter int bw    = 4,
  parameter int col   = 8,
  parameter int depth = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [bw-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          cmd_valid,
  input  logic          cmd_op,
  input  logic [7:0]    cmd_len,
  output logic          cmd_ready,
  output logic [bw-1:0] out_w,
  output logic [1:0]    inst_w,
  output logic          busy,
  output logic          done
`ifdef WEST_FEEDER_OCC_EN
  ,
  output logic [$clog2(depth):0] occ
`endif
);

  localparam int            c_AW    = $clog2(depth);
  localparam logic [7:0]    c_COL   = 8'(col);
  localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(depth);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [bw-1:0]   r_mem [depth];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_count;
  logic            r_op;
  logic [7:0]      r_len;
  logic [7:0]      r_items;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [7:0]      w_target;
  logic            w_last;

  assign w_full    = (r_count == c_DEPTH);
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full && !reset;
  assign cmd_ready = (r_state == S_IDLE) && !reset;
  assign busy      = (r_state != S_IDLE);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = ((r_state == S_LOAD) || (r_state == S_EXEC)) && !w_empty;
  assign w_target  = r_op ? r_len : c_COL;
  assign w_last    = ((r_items + 8'd1) == w_target);

  // Storage carries no reset: only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_len   <= 8'd0;
      r_items <= 8'd0;
      out_w   <= '0;
      inst_w  <= 2'b00;
      done    <= 1'b0;
    end else begin
      inst_w <= 2'b00;
      done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_len   <= cmd_len;
            r_items <= 8'd0;
            if (!cmd_op) begin
              r_state <= S_LOAD;
            end else if (cmd_len == 8'd0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_LOAD, S_EXEC: begin
          // An empty FIFO stalls: out_w holds and the item count stays put.
          if (w_pop) begin
            out_w   <= r_mem[r_rptr];
            inst_w  <= (r_state == S_LOAD) ? 2'b01 : 2'b10;
            r_items <= r_items + 8'd1;
            if (w_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef WEST_FEEDER_OCC_EN
  assign occ = r_count;
`endif

endmodule
`default_nettype wire
